// File: rtl/memory_port_arbiter_mips.sv
// Arbitrates one single-port, fixed-latency memory between Fetch and MemoryAccess.
// Optional fetch anti-starvation guard: define FETCH_STARVATION_GUARD_EN.
module memory_port_arbiter_mips #(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int MEMORY_LATENCY   = 2,
  parameter int STARVATION_LIMIT = 4
) (
  input  logic                     clock,
  input  logic                     resetMachineN,
  input  logic                     requestRead_Fetch,
  input  logic [ADDRESS_WIDTH-1:0] address_Fetch,
  input  logic                     flushFetch_HazardUnit,
  input  logic                     enableReadDataMemory_MemoryAccess,
  input  logic                     enableWriteDataMemory_MemoryAccess,
  input  logic [ADDRESS_WIDTH-1:0] address_MemoryAccess,
  input  logic [DATA_WIDTH-1:0]    writeData_MemoryAccess,
  input  logic [DATA_WIDTH-1:0]    memoryReadData,
  output logic                     memoryEnable,
  output logic                     memoryWriteEnable,
  output logic [ADDRESS_WIDTH-1:0] memoryAddress,
  output logic [DATA_WIDTH-1:0]    memoryWriteData,
  output logic [DATA_WIDTH-1:0]    instruction_Arbiter,
  output logic                     validInstruction_Arbiter,
  output logic [DATA_WIDTH-1:0]    readData_Arbiter,
  output logic                     validData_Arbiter,
  output logic                     stallFetch_Arbiter,
  output logic                     stallMemoryAccess_Arbiter
);
  localparam int CW = (MEMORY_LATENCY > 1) ? $clog2(MEMORY_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_FETCH, BUSY_DATA} state_t;
  state_t state, nextState;

  logic [CW-1:0] latencyCounter;
  logic          fetchDead;
  logic          dataRequest, fetchEligible, dataEligible, contested;
  logic          forceFetch, grantFetch, grantData, lastBeat;

  assign dataRequest   = enableReadDataMemory_MemoryAccess | enableWriteDataMemory_MemoryAccess;
  // A held request is ineligible while its own completion pulse is up.
  assign fetchEligible = requestRead_Fetch & ~validInstruction_Arbiter;
  assign dataEligible  = dataRequest & ~validData_Arbiter;
  assign contested     = fetchEligible & dataEligible;
  assign lastBeat      = (latencyCounter == CW'(MEMORY_LATENCY - 1));

`ifdef FETCH_STARVATION_GUARD_EN
  localparam int SW = $clog2(STARVATION_LIMIT + 1);
  logic [SW-1:0] starvationCounter;

  assign forceFetch = contested && (starvationCounter >= SW'(STARVATION_LIMIT));

  always_ff @(posedge clock or negedge resetMachineN) begin
    if (!resetMachineN)            starvationCounter <= '0;
    else if (grantFetch)           starvationCounter <= '0;
    else if (grantData && contested) starvationCounter <= starvationCounter + 1'b1;
  end
`else
  assign forceFetch = 1'b0;
`endif

  assign grantData  = (state == IDLE) && dataEligible && !forceFetch;
  assign grantFetch = (state == IDLE) && fetchEligible && !grantData;

  // Stalls are forced low during reset so every output reads 0.
  assign stallFetch_Arbiter        = resetMachineN & requestRead_Fetch & ~validInstruction_Arbiter;
  assign stallMemoryAccess_Arbiter = resetMachineN & dataRequest & ~validData_Arbiter;

  always_ff @(posedge clock or negedge resetMachineN) begin
    if (!resetMachineN) state <= IDLE;
    else                state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (grantData)       nextState = BUSY_DATA;
        else if (grantFetch) nextState = BUSY_FETCH;
      end
      BUSY_FETCH, BUSY_DATA: if (lastBeat) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetMachineN) begin
    if (!resetMachineN) begin
      memoryEnable             <= 1'b0;
      memoryWriteEnable        <= 1'b0;
      memoryAddress            <= '0;
      memoryWriteData          <= '0;
      instruction_Arbiter      <= '0;
      validInstruction_Arbiter <= 1'b0;
      readData_Arbiter         <= '0;
      validData_Arbiter        <= 1'b0;
      latencyCounter           <= '0;
      fetchDead                <= 1'b0;
    end else begin
      validInstruction_Arbiter <= 1'b0;
      validData_Arbiter        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grantData) begin
            memoryEnable      <= 1'b1;
            memoryWriteEnable <= enableWriteDataMemory_MemoryAccess;
            memoryAddress     <= address_MemoryAccess;
            memoryWriteData   <= writeData_MemoryAccess;
            latencyCounter    <= '0;
          end else if (grantFetch) begin
            memoryEnable      <= 1'b1;
            memoryWriteEnable <= 1'b0;
            memoryAddress     <= address_Fetch;
            latencyCounter    <= '0;
            fetchDead         <= 1'b0;
          end
        end
        BUSY_FETCH: begin
          if (flushFetch_HazardUnit) fetchDead <= 1'b1;
          if (lastBeat) begin
            memoryEnable <= 1'b0;
            // A flush on the completing edge also kills the result.
            if (!fetchDead && !flushFetch_HazardUnit) begin
              instruction_Arbiter      <= memoryReadData;
              validInstruction_Arbiter <= 1'b1;
            end
          end else begin
            latencyCounter <= latencyCounter + 1'b1;
          end
        end
        BUSY_DATA: begin
          if (lastBeat) begin
            memoryEnable      <= 1'b0;
            memoryWriteEnable <= 1'b0;
            validData_Arbiter <= 1'b1;
            if (!memoryWriteEnable) readData_Arbiter <= memoryReadData;
          end else begin
            latencyCounter <= latencyCounter + 1'b1;
          end
        end
        default: memoryEnable <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_port_arbiter_mips.sv
// Directed bench for memory_port_arbiter_mips (MEMORY_LATENCY=2, STARVATION_LIMIT=2).
module tb_memory_port_arbiter_mips;
  logic        clock = 1'b0;
  logic        resetMachineN;
  logic        requestRead_Fetch;
  logic [31:0] address_Fetch;
  logic        flushFetch_HazardUnit;
  logic        enableReadDataMemory_MemoryAccess;
  logic        enableWriteDataMemory_MemoryAccess;
  logic [31:0] address_MemoryAccess;
  logic [31:0] writeData_MemoryAccess;
  logic [31:0] memoryReadData;
  logic        memoryEnable, memoryWriteEnable;
  logic [31:0] memoryAddress, memoryWriteData;
  logic [31:0] instruction_Arbiter, readData_Arbiter;
  logic        validInstruction_Arbiter, validData_Arbiter;
  logic        stallFetch_Arbiter, stallMemoryAccess_Arbiter;

  int checks = 0;
  int failures = 0;
  logic [31:0] fetchQ[$];
  logic [31:0] dataQ[$];

  always #5 clock = ~clock;

  memory_port_arbiter_mips #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEMORY_LATENCY(2), .STARVATION_LIMIT(2)
  ) dut (
    .clock(clock), .resetMachineN(resetMachineN),
    .requestRead_Fetch(requestRead_Fetch), .address_Fetch(address_Fetch),
    .flushFetch_HazardUnit(flushFetch_HazardUnit),
    .enableReadDataMemory_MemoryAccess(enableReadDataMemory_MemoryAccess),
    .enableWriteDataMemory_MemoryAccess(enableWriteDataMemory_MemoryAccess),
    .address_MemoryAccess(address_MemoryAccess), .writeData_MemoryAccess(writeData_MemoryAccess),
    .memoryReadData(memoryReadData), .memoryEnable(memoryEnable),
    .memoryWriteEnable(memoryWriteEnable), .memoryAddress(memoryAddress),
    .memoryWriteData(memoryWriteData), .instruction_Arbiter(instruction_Arbiter),
    .validInstruction_Arbiter(validInstruction_Arbiter), .readData_Arbiter(readData_Arbiter),
    .validData_Arbiter(validData_Arbiter), .stallFetch_Arbiter(stallFetch_Arbiter),
    .stallMemoryAccess_Arbiter(stallMemoryAccess_Arbiter)
  );

  function automatic logic [31:0] memModel(input logic [31:0] a);
    return (a == 32'h0000_0040) ? 32'h2008_0005 : (a ^ 32'hA5A5_0000);
  endfunction

  assign memoryReadData = memoryEnable ? memModel(memoryAddress) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: completion pulses pop the expected result queued at stimulus time.
  always @(negedge clock) begin
    if (validInstruction_Arbiter) begin
      if (fetchQ.size() == 0) chk("unexpected_validInstruction", validInstruction_Arbiter, 0);
      else chk("sb_instruction", instruction_Arbiter, fetchQ.pop_front());
    end
    if (validData_Arbiter) begin
      if (dataQ.size() == 0) chk("unexpected_validData", validData_Arbiter, 0);
      else chk("sb_readData", readData_Arbiter, dataQ.pop_front());
    end
  end

  // One contested round: data wins unless the guard forces fetch.
  task automatic contest(input bit fetchWins);
    requestRead_Fetch = 1; address_Fetch = 32'h0000_00C0;
    enableReadDataMemory_MemoryAccess = 1; address_MemoryAccess = 32'h0000_2000;
    if (fetchWins) fetchQ.push_back(memModel(32'h0000_00C0));
    dataQ.push_back(memModel(32'h0000_2000));
    step();
    chk("contest_grantAddr", memoryAddress, fetchWins ? 32'h0000_00C0 : 32'h0000_2000);
    step(); step();
    if (fetchWins) begin
      chk("contest_validInstr", validInstruction_Arbiter, 1);
      requestRead_Fetch = 0;
      step(); step(); step();
      chk("contest_validDataLate", validData_Arbiter, 1);
    end else begin
      chk("contest_validData", validData_Arbiter, 1);
      requestRead_Fetch = 0;
    end
    enableReadDataMemory_MemoryAccess = 0;
    step();
  endtask

  initial begin
    resetMachineN = 0; requestRead_Fetch = 0; address_Fetch = 0; flushFetch_HazardUnit = 0;
    enableReadDataMemory_MemoryAccess = 0; enableWriteDataMemory_MemoryAccess = 0;
    address_MemoryAccess = 0; writeData_MemoryAccess = 0;
    step(); step();
    chk("reset_memoryEnable", memoryEnable, 0);
    chk("reset_instruction", instruction_Arbiter, 0);
    resetMachineN = 1;
    step();
    chk("idle_memoryEnable", memoryEnable, 0);

    // Lone fetch
    requestRead_Fetch = 1; address_Fetch = 32'h0000_0040; fetchQ.push_back(32'h2008_0005);
    #1 chk("fetch_c0_stall", stallFetch_Arbiter, 1);
    chk("fetch_c0_memEn", memoryEnable, 0);
    step(); chk("fetch_c1_memEn", memoryEnable, 1);
    chk("fetch_c1_addr", memoryAddress, 32'h0000_0040);
    chk("fetch_c1_stall", stallFetch_Arbiter, 1);
    step(); chk("fetch_c2_memEn", memoryEnable, 1);
    step(); chk("fetch_c3_valid", validInstruction_Arbiter, 1);
    chk("fetch_c3_instr", instruction_Arbiter, 32'h2008_0005);
    chk("fetch_c3_stall", stallFetch_Arbiter, 0);
    chk("fetch_c3_memEn", memoryEnable, 0);
    requestRead_Fetch = 0;
    step(); chk("fetch_c4_valid", validInstruction_Arbiter, 0);

    // Fetch and load together: data first
    requestRead_Fetch = 1; address_Fetch = 32'h0000_0080;
    enableReadDataMemory_MemoryAccess = 1; address_MemoryAccess = 32'h0000_1000;
    dataQ.push_back(memModel(32'h0000_1000)); fetchQ.push_back(memModel(32'h0000_0080));
    #1 chk("both_c0_stallMA", stallMemoryAccess_Arbiter, 1);
    step(); chk("both_c1_addr", memoryAddress, 32'h0000_1000);
    chk("both_c1_we", memoryWriteEnable, 0);
    step(); step();
    chk("both_c3_validData", validData_Arbiter, 1);
    chk("both_c3_stallMA", stallMemoryAccess_Arbiter, 0);
    chk("both_c3_stallF", stallFetch_Arbiter, 1);
    enableReadDataMemory_MemoryAccess = 0;
    step(); chk("both_c4_addr", memoryAddress, 32'h0000_0080);
    chk("both_c4_memEn", memoryEnable, 1);
    step(); step();
    chk("both_c6_validInstr", validInstruction_Arbiter, 1);
    requestRead_Fetch = 0;
    step();

    // Store with load also high: store wins, readData unchanged
    enableWriteDataMemory_MemoryAccess = 1; enableReadDataMemory_MemoryAccess = 1;
    address_MemoryAccess = 32'h0000_0010; writeData_MemoryAccess = 32'hDEAD_BEEF;
    dataQ.push_back(memModel(32'h0000_1000));
    step(); chk("store_c1_we", memoryWriteEnable, 1);
    chk("store_c1_wdata", memoryWriteData, 32'hDEAD_BEEF);
    chk("store_c1_addr", memoryAddress, 32'h0000_0010);
    step(); chk("store_c2_we", memoryWriteEnable, 1);
    step(); chk("store_c3_validData", validData_Arbiter, 1);
    chk("store_c3_readData", readData_Arbiter, memModel(32'h0000_1000));
    chk("store_c3_we", memoryWriteEnable, 0);
    enableWriteDataMemory_MemoryAccess = 0; enableReadDataMemory_MemoryAccess = 0;
    step();

    // Flush on the completing edge of a lone fetch
    requestRead_Fetch = 1; address_Fetch = 32'h0000_0040;
    step(); chk("flush_c1_memEn", memoryEnable, 1);
    step(); chk("flush_c2_memEn", memoryEnable, 1);
    flushFetch_HazardUnit = 1;
    step(); flushFetch_HazardUnit = 0;
    chk("flush_c3_valid", validInstruction_Arbiter, 0);
    chk("flush_c3_memEn", memoryEnable, 0);
    chk("flush_c3_instr", instruction_Arbiter, memModel(32'h0000_0080));
    requestRead_Fetch = 0;
    step(); chk("flush_c4_valid", validInstruction_Arbiter, 0);

    // Repeated contention: guard forces fetch on the third round
    contest(1'b0);
    contest(1'b0);
`ifdef FETCH_STARVATION_GUARD_EN
    contest(1'b1);
`else
    contest(1'b0);
`endif

    // Asynchronous reset mid-transfer
    requestRead_Fetch = 1; address_Fetch = 32'h0000_0040;
    step(); chk("rst_pre_memEn", memoryEnable, 1);
    resetMachineN = 0;
    #1;
    chk("rst_memEn", memoryEnable, 0);
    chk("rst_addr", memoryAddress, 0);
    chk("rst_instr", instruction_Arbiter, 0);
    chk("rst_readData", readData_Arbiter, 0);
    chk("rst_stallF", stallFetch_Arbiter, 0);
    requestRead_Fetch = 0;
    step(); resetMachineN = 1;
    step(); step(); step();
    chk("rst_after_memEn", memoryEnable, 0);
    chk("rst_after_valid", validInstruction_Arbiter, 0);
    chk("fetchQ_drained", fetchQ.size(), 0);
    chk("dataQ_drained", dataQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
